// File: rtl/hdd_pwr_mon_pkg.sv
// Shared definitions for the HDD power monitor: channel/handshake state encodings
// and default timing constants.
package hdd_pwr_mon_pkg;

  typedef enum logic [1:0] {
    CH_OFF   = 2'd0,
    CH_RAMP  = 2'd1,
    CH_ON    = 2'd2,
    CH_FAULT = 2'd3
  } chan_state_e;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_HOLD = 1'b1
  } clr_state_e;

  localparam int DEF_NUM_HDD    = 15;
  localparam int DEF_DEB_TICKS  = 8;
  localparam int DEF_PG_TIMEOUT = 200;

endpackage

// File: rtl/hdd_chan_mon.sv
// One drive bay: input synchronisers, presence debounce, power channel FSM,
// sticky fault and presence-change bits.
module hdd_chan_mon
  import hdd_pwr_mon_pkg::*;
#(
  parameter int DEB_TICKS  = DEF_DEB_TICKS,
  parameter int PG_TIMEOUT = DEF_PG_TIMEOUT
) (
  input  logic SYSCLK,
  input  logic RESET_N,
  input  logic TICK_1MS,
  input  logic HDD_PRSNT_L,
  input  logic HDD_PG,
  input  logic PWR_EN_HDD_L,
  input  logic CLR,
  output logic PRSNT_STS,
  output logic PG_STS,
  output logic FAULT_STS,
  output logic CHG_STS
);

  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam int TW = $clog2(PG_TIMEOUT + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_TICKS - 1);
  localparam logic [TW-1:0] TMO      = TW'(PG_TIMEOUT);

  logic          prsnt_meta_r, prsnt_sync_r, prsnt_prev_r;
  logic          pg_meta_r, pg_sync_r;
  logic [DW-1:0] deb_cnt_r, deb_cnt_s;
  logic          stable_r, stable_s;
  logic          init_done_r, init_done_s;
  logic          chg_evt_s, deb_hit_s;
  chan_state_e   state_r, state_s;
  logic [TW-1:0] timer_r, timer_s;
  logic          chan_ok_s, fault_set_s;
  logic          fault_r, chg_r, pg_sts_r;

  assign deb_hit_s = TICK_1MS && (deb_cnt_r >= DEB_LAST);

  // Debounce next-state; until the first resolve the reference is the previous
  // synced sample, so the initial presence is learned without flagging a change.
  always_comb begin
    deb_cnt_s   = deb_cnt_r;
    stable_s    = stable_r;
    init_done_s = init_done_r;
    chg_evt_s   = 1'b0;
    if (!init_done_r) begin
      if (prsnt_sync_r != prsnt_prev_r) begin
        deb_cnt_s = '0;
      end else if (deb_hit_s) begin
        deb_cnt_s   = '0;
        stable_s    = prsnt_sync_r;
        init_done_s = 1'b1;
      end else if (TICK_1MS) begin
        deb_cnt_s = deb_cnt_r + DW'(1);
      end else begin
        deb_cnt_s = deb_cnt_r;
      end
    end else if (prsnt_sync_r != stable_r) begin
      if (deb_hit_s) begin
        deb_cnt_s = '0;
        stable_s  = prsnt_sync_r;
        chg_evt_s = 1'b1;
      end else if (TICK_1MS) begin
        deb_cnt_s = deb_cnt_r + DW'(1);
      end else begin
        deb_cnt_s = deb_cnt_r;
      end
    end else begin
      deb_cnt_s = '0;
    end
  end

  // Synchronisers and debounce state.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      prsnt_meta_r <= 1'b0;
      prsnt_sync_r <= 1'b0;
      prsnt_prev_r <= 1'b0;
      pg_meta_r    <= 1'b0;
      pg_sync_r    <= 1'b0;
      deb_cnt_r    <= '0;
      stable_r     <= 1'b0;
      init_done_r  <= 1'b0;
    end else begin
      prsnt_meta_r <= ~HDD_PRSNT_L;
      prsnt_sync_r <= prsnt_meta_r;
      prsnt_prev_r <= prsnt_sync_r;
      pg_meta_r    <= HDD_PG;
      pg_sync_r    <= pg_meta_r;
      deb_cnt_r    <= deb_cnt_s;
      stable_r     <= stable_s;
      init_done_r  <= init_done_s;
    end
  end

  assign chan_ok_s = stable_r & ~PWR_EN_HDD_L;

  // Channel FSM next-state; losing enable or presence beats power-good and timeout.
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    case (state_r)
      CH_OFF: begin
        timer_s = '0;
        if (chan_ok_s) state_s = CH_RAMP;
        else           state_s = CH_OFF;
      end
      CH_RAMP: begin
        if (!chan_ok_s)          state_s = CH_OFF;
        else if (pg_sync_r)      state_s = CH_ON;
        else if (timer_r >= TMO) state_s = CH_FAULT;
        else if (TICK_1MS)       timer_s = timer_r + TW'(1);
        else                     timer_s = timer_r;
      end
      CH_ON: begin
        if (!chan_ok_s)      state_s = CH_OFF;
        else if (!pg_sync_r) state_s = CH_FAULT;
        else                 state_s = CH_ON;
      end
      CH_FAULT: begin
        if (!chan_ok_s) state_s = CH_OFF;
        else            state_s = CH_FAULT;
      end
      default: begin
        state_s = CH_OFF;
        timer_s = '0;
      end
    endcase
  end

  assign fault_set_s = (state_s == CH_FAULT) && (state_r != CH_FAULT);

  // Channel state, ramp timer and sticky status; a new event outranks a clear.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r  <= CH_OFF;
      timer_r  <= '0;
      pg_sts_r <= 1'b0;
      fault_r  <= 1'b0;
      chg_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      timer_r  <= timer_s;
      pg_sts_r <= (state_r == CH_ON);
      if (fault_set_s) fault_r <= 1'b1;
      else if (CLR)    fault_r <= 1'b0;
      else             fault_r <= fault_r;
      if (chg_evt_s)   chg_r <= 1'b1;
      else if (CLR)    chg_r <= 1'b0;
      else             chg_r <= chg_r;
    end
  end

  assign PRSNT_STS = stable_r;
  assign PG_STS    = pg_sts_r;
  assign FAULT_STS = fault_r;
  assign CHG_STS   = chg_r;

endmodule

// File: rtl/hdd_pwr_mon.sv
// HDD power readback monitor: one channel monitor per bay, the req/ack
// write-1-to-clear handshake and the shared alert.
module hdd_pwr_mon
  import hdd_pwr_mon_pkg::*;
#(
  parameter int NUM_HDD    = DEF_NUM_HDD,
  parameter int DEB_TICKS  = DEF_DEB_TICKS,
  parameter int PG_TIMEOUT = DEF_PG_TIMEOUT
) (
  input  logic               SYSCLK,
  input  logic               RESET_N,
  input  logic               TICK_1MS,
  input  logic [NUM_HDD-1:0] HDD_PRSNT_L,
  input  logic [NUM_HDD-1:0] HDD_PG,
  input  logic [NUM_HDD-1:0] PWR_EN_HDD_L,
  input  logic               CLR_REQ,
  input  logic [NUM_HDD-1:0] CLR_MASK,
  output logic               CLR_ACK,
  output logic [NUM_HDD-1:0] PRSNT_STS,
  output logic [NUM_HDD-1:0] PG_STS,
  output logic [NUM_HDD-1:0] FAULT_STS,
  output logic [NUM_HDD-1:0] CHG_STS,
  output logic               HDD_ALERT_L
);

  clr_state_e         clr_state_r, clr_state_s;
  logic               clr_fire_s;
  logic [NUM_HDD-1:0] clr_vec_s;
  logic               alert_r;

  // Clear handshake: fire once on request entry, then hold ack until request drops.
  always_comb begin
    clr_state_s = clr_state_r;
    clr_fire_s  = 1'b0;
    case (clr_state_r)
      CLR_IDLE: begin
        if (CLR_REQ) begin
          clr_fire_s  = 1'b1;
          clr_state_s = CLR_HOLD;
        end else begin
          clr_state_s = CLR_IDLE;
        end
      end
      CLR_HOLD: begin
        if (!CLR_REQ) clr_state_s = CLR_IDLE;
        else          clr_state_s = CLR_HOLD;
      end
      default: clr_state_s = CLR_IDLE;
    endcase
  end

  assign clr_vec_s = CLR_MASK & {NUM_HDD{clr_fire_s}};

  for (genvar g = 0; g < NUM_HDD; g++) begin : g_chan
    hdd_chan_mon #(
      .DEB_TICKS  (DEB_TICKS),
      .PG_TIMEOUT (PG_TIMEOUT)
    ) u_chan (
      .SYSCLK       (SYSCLK),
      .RESET_N      (RESET_N),
      .TICK_1MS     (TICK_1MS),
      .HDD_PRSNT_L  (HDD_PRSNT_L[g]),
      .HDD_PG       (HDD_PG[g]),
      .PWR_EN_HDD_L (PWR_EN_HDD_L[g]),
      .CLR          (clr_vec_s[g]),
      .PRSNT_STS    (PRSNT_STS[g]),
      .PG_STS       (PG_STS[g]),
      .FAULT_STS    (FAULT_STS[g]),
      .CHG_STS      (CHG_STS[g])
    );
  end

  // Handshake state and registered alert.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      clr_state_r <= CLR_IDLE;
      alert_r     <= 1'b1;
    end else begin
      clr_state_r <= clr_state_s;
      alert_r     <= ~|(FAULT_STS | CHG_STS);
    end
  end

  assign CLR_ACK     = (clr_state_r == CLR_HOLD);
  assign HDD_ALERT_L = alert_r;

endmodule
